// File: rtl/ace_snoop_responder_pkg.sv
// Shared types for the ACE snoop responder: opcodes, CRRESP bit positions,
// FSM states and the decoded per-snoop action.
package ace_snoop_pkg;

    localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

    localparam int CR_DT  = 0;
    localparam int CR_ERR = 1;
    localparam int CR_PD  = 2;
    localparam int CR_IS  = 3;
    localparam int CR_WU  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_LKP,
        ST_RESP,
        ST_DATA_RD,
        ST_DATA_WAIT,
        ST_DATA_SEND,
        ST_UPDATE
    } snoop_state_e;

    typedef struct packed {
        logic dt;
        logic pd;
        logic is;
        logic wu;
        logic inval;
        logic clean;
        logic share;
    } snoop_action_t;

    // Error is never signalled by this responder.
    function automatic logic [4:0] crresp(input snoop_action_t a);
        logic [4:0] r;
        r         = '0;
        r[CR_DT]  = a.dt;
        r[CR_ERR] = 1'b0;
        r[CR_PD]  = a.pd;
        r[CR_IS]  = a.is;
        r[CR_WU]  = a.wu;
        return r;
    endfunction

    function automatic int beat_width(input int line_bytes, input int data_width);
        int beats;
        beats = line_bytes * 8 / data_width;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ace_snoop_responder_if.sv
// Snoop-side bus bundle: AC/CR/CD channels plus the cache lookup, read and update ports.
// Handshakes: a transfer happens on a clock edge where valid (or req) and ready (or gnt) are both 1;
// once raised, valid/req and its payload stay stable until that edge.
interface ace_snoop_responder_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int BeatW     = 3
);
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;
    logic [2:0]           ac_prot_i;
    logic                 cr_valid_o;
    logic                 cr_ready_i;
    logic [4:0]           cr_resp_o;
    logic                 cd_valid_o;
    logic                 cd_ready_i;
    logic [DataWidth-1:0] cd_data_o;
    logic                 cd_last_o;
    logic                 lkp_req_o;
    logic                 lkp_gnt_i;
    logic [AddrWidth-1:0] lkp_addr_o;
    logic                 lkp_valid_i;
    logic                 lkp_hit_i;
    logic                 lkp_dirty_i;
    logic                 lkp_shared_i;
    logic                 rd_req_o;
    logic                 rd_gnt_i;
    logic [BeatW-1:0]     rd_beat_o;
    logic                 rd_valid_i;
    logic [DataWidth-1:0] rd_data_i;
    logic                 upd_valid_o;
    logic                 upd_inval_o;
    logic                 upd_clean_o;
    logic                 upd_share_o;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
               lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i,
               rd_gnt_i, rd_valid_i, rd_data_i,
        output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
               lkp_req_o, lkp_addr_o, rd_req_o, rd_beat_o,
               upd_valid_o, upd_inval_o, upd_clean_o, upd_share_o
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
               lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i,
               rd_gnt_i, rd_valid_i, rd_data_i,
        input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
               lkp_req_o, lkp_addr_o, rd_req_o, rd_beat_o,
               upd_valid_o, upd_inval_o, upd_clean_o, upd_share_o
    );
endinterface

// File: rtl/ace_snoop_responder_decoder.sv
// Maps a snoop opcode and the looked-up line state to the response and cache-state update.
module ace_snoop_decoder
    import ace_snoop_pkg::*;
(
    input  logic [3:0]    op_i,
    input  logic          hit_i,
    input  logic          dirty_i,
    input  logic          shared_i,
    output snoop_action_t act_o
);
    always_comb begin
        act_o = '0;
        if (hit_i) begin
            case (op_i)
                SNP_READ_ONCE: begin
                    act_o.dt = 1'b1; act_o.is = 1'b1; act_o.wu = !shared_i;
                end
                SNP_READ_SHARED, SNP_READ_NSD: begin
                    act_o.dt = 1'b1; act_o.pd = dirty_i; act_o.is = 1'b1; act_o.wu = !shared_i;
                    act_o.share = 1'b1; act_o.clean = dirty_i;
                end
                SNP_READ_CLEAN: begin
                    act_o.dt = 1'b1; act_o.is = 1'b1; act_o.wu = !shared_i; act_o.share = 1'b1;
                end
                SNP_READ_UNIQUE: begin
                    act_o.dt = 1'b1; act_o.pd = dirty_i; act_o.wu = !shared_i; act_o.inval = 1'b1;
                end
                SNP_CLEAN_INVALID: begin
                    act_o.dt = dirty_i; act_o.pd = dirty_i; act_o.wu = !shared_i; act_o.inval = 1'b1;
                end
                SNP_CLEAN_SHARED: begin
                    act_o.dt = dirty_i; act_o.pd = dirty_i; act_o.is = 1'b1; act_o.wu = !shared_i;
                    act_o.clean = dirty_i;
                end
                SNP_MAKE_INVALID: begin
                    act_o.wu = !shared_i; act_o.inval = 1'b1;
                end
                default: act_o = '0;
            endcase
        end
    end
endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: one snoop at a time through lookup, CR response, optional CD line
// transfer and a single cache-state update.
module ace_snoop_responder
    import ace_snoop_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineBytes = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ace_snoop_responder_if.slave  bus,
    output snoop_state_e          dbg_state_o
);
    localparam int Beats = LineBytes * 8 / DataWidth;
    localparam int BeatW = beat_width(LineBytes, DataWidth);
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(LineBytes - 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

    snoop_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           op_q, op_d;
    logic                 hit_q, hit_d, dirty_q, dirty_d, shared_q, shared_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic [DataWidth-1:0] data_q, data_d;
    snoop_action_t        act;
    logic                 has_upd, last_beat;
    logic                 unused_prot;

    ace_snoop_decoder u_dec (
        .op_i     (op_q),
        .hit_i    (hit_q),
        .dirty_i  (dirty_q),
        .shared_i (shared_q),
        .act_o    (act)
    );

    assign has_upd        = act.inval | act.clean | act.share;
    assign last_beat      = (beat_q == LastBeat);
    assign bus.lkp_addr_o = addr_q;
    assign bus.rd_beat_o  = beat_q;
    assign dbg_state_o    = state_q;
    assign unused_prot    = ^bus.ac_prot_i;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_d     = op_q;
        hit_d    = hit_q;
        dirty_d  = dirty_q;
        shared_d = shared_q;
        beat_d   = beat_q;
        data_d   = data_q;
        bus.ac_ready_o  = 1'b0;
        bus.lkp_req_o   = 1'b0;
        bus.cr_valid_o  = 1'b0;
        bus.cr_resp_o   = '0;
        bus.rd_req_o    = 1'b0;
        bus.cd_valid_o  = 1'b0;
        bus.cd_data_o   = '0;
        bus.cd_last_o   = 1'b0;
        bus.upd_valid_o = 1'b0;
        bus.upd_inval_o = 1'b0;
        bus.upd_clean_o = 1'b0;
        bus.upd_share_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Not ready while reset is held, even though the state already reads IDLE.
                bus.ac_ready_o = !rst_i;
                if (bus.ac_valid_i) begin
                    addr_d  = bus.ac_addr_i & ~OffMask;
                    op_d    = bus.ac_snoop_i;
                    beat_d  = '0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                bus.lkp_req_o = 1'b1;
                if (bus.lkp_gnt_i) state_d = ST_WAIT_LKP;
            end
            ST_WAIT_LKP: begin
                if (bus.lkp_valid_i) begin
                    hit_d    = bus.lkp_hit_i;
                    dirty_d  = bus.lkp_dirty_i;
                    shared_d = bus.lkp_shared_i;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.cr_valid_o = 1'b1;
                bus.cr_resp_o  = crresp(act);
                if (bus.cr_ready_i) begin
                    beat_d = '0;
                    if (act.dt)       state_d = ST_DATA_RD;
                    else if (has_upd) state_d = ST_UPDATE;
                    else              state_d = ST_IDLE;
                end
            end
            ST_DATA_RD: begin
                bus.rd_req_o = 1'b1;
                if (bus.rd_gnt_i) state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: begin
                if (bus.rd_valid_i) begin
                    data_d  = bus.rd_data_i;
                    state_d = ST_DATA_SEND;
                end
            end
            ST_DATA_SEND: begin
                bus.cd_valid_o = 1'b1;
                bus.cd_data_o  = data_q;
                bus.cd_last_o  = last_beat;
                if (bus.cd_ready_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = has_upd ? ST_UPDATE : ST_IDLE;
                    end else begin
                        beat_d  = beat_q + BeatW'(1);
                        state_d = ST_DATA_RD;
                    end
                end
            end
            ST_UPDATE: begin
                bus.upd_valid_o = 1'b1;
                bus.upd_inval_o = act.inval;
                bus.upd_clean_o = act.clean;
                bus.upd_share_o = act.share;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            op_q     <= '0;
            hit_q    <= 1'b0;
            dirty_q  <= 1'b0;
            shared_q <= 1'b0;
            beat_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            hit_q    <= hit_d;
            dirty_q  <= dirty_d;
            shared_q <= shared_d;
            beat_q   <= beat_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Cycle-exact bench for ace_snoop_responder: acts as cache and interconnect, checks every cycle.
module tb_ace_snoop_responder;
    import ace_snoop_pkg::*;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int LINE_BYTES = 64;
    localparam int BEATS      = LINE_BYTES * 8 / DATA_W;
    localparam int BEAT_W     = beat_width(LINE_BYTES, DATA_W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    snoop_state_e dbg_state;
    int n_vec = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    ace_snoop_responder_if #(.AddrWidth(ADDR_W), .DataWidth(DATA_W), .BeatW(BEAT_W)) bus ();

    ace_snoop_responder #(.AddrWidth(ADDR_W), .DataWidth(DATA_W), .LineBytes(LINE_BYTES)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour expressed by snoop semantics rather than per-opcode rows.
    function automatic void ref_model(input logic [3:0] op, input bit hit, input bit d, input bit s,
                                      output logic [4:0] resp, output bit dt, output logic [2:0] upd);
        bit known, is_read, kills, keeps, pd, clean, share;
        known   = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
        is_read = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
        kills   = op inside {4'd7, 4'd9, 4'd13};
        keeps   = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
        pd      = d && (op inside {4'd1, 4'd3, 4'd7, 4'd8, 4'd9});
        clean   = d && (op inside {4'd1, 4'd3, 4'd8});
        share   = op inside {4'd1, 4'd2, 4'd3};
        resp = 5'b0;
        dt   = 1'b0;
        upd  = 3'b0;
        if (hit && known) begin
            dt   = is_read ? 1'b1 : ((op == 4'd13) ? 1'b0 : d);
            resp = {!s, keeps, pd, 1'b0, dt};
            upd  = {kills, clean, share};
        end
    endfunction

    function automatic logic [63:0] line_word(input logic [63:0] line, input int b);
        return {line[31:0] ^ (32'(b) * 32'h9E37_79B1), 32'hC0DE_0000 | 32'(b)};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, {bus.ac_ready_o, bus.cr_valid_o, bus.cr_resp_o, bus.cd_valid_o,
                               bus.cd_last_o, bus.lkp_req_o, bus.rd_req_o, bus.upd_valid_o,
                               bus.upd_inval_o, bus.upd_clean_o, bus.upd_share_o}, 64'd0);
        check({tag, "_cd_data"}, bus.cd_data_o, 64'd0);
        check({tag, "_lkp_addr"}, bus.lkp_addr_o, 64'd0);
        check({tag, "_rd_beat"}, 64'(bus.rd_beat_o), 64'd0);
    endtask

    task automatic run_snoop(input logic [3:0] op, input logic [63:0] addr, input bit hit,
                             input bit dirty, input bit shared, input int max_dly,
                             input int cr_stall, input int rst_beat);
        logic [4:0] e_resp;
        bit e_dt;
        logic [2:0] e_upd;
        logic [63:0] line, w;
        int stall;
        ref_model(op, hit, dirty, shared, e_resp, e_dt, e_upd);
        line = addr & ~64'(LINE_BYTES - 1);
        check("ac_ready_idle", bus.ac_ready_o, 1);
        bus.ac_valid_i = 1'b1;
        bus.ac_addr_i  = addr;
        bus.ac_snoop_i = op;
        bus.ac_prot_i  = 3'($urandom_range(0, 7));
        step();
        bus.ac_valid_i = 1'b0;
        bus.ac_addr_i  = {$urandom, $urandom};
        bus.ac_snoop_i = 4'($urandom_range(0, 15));
        check("ac_ready_busy", bus.ac_ready_o, 0);
        repeat ($urandom_range(0, max_dly)) begin
            check("lkp_req_hold", bus.lkp_req_o, 1);
            step();
        end
        check("lkp_req", bus.lkp_req_o, 1);
        check("lkp_addr", bus.lkp_addr_o, line);
        bus.lkp_gnt_i = 1'b1;
        step();
        bus.lkp_gnt_i = 1'b0;
        check("lkp_req_drop", bus.lkp_req_o, 0);
        repeat ($urandom_range(0, max_dly)) begin
            check("cr_early", bus.cr_valid_o, 0);
            step();
        end
        bus.lkp_valid_i = 1'b1;
        {bus.lkp_hit_i, bus.lkp_dirty_i, bus.lkp_shared_i} = {hit, dirty, shared};
        step();
        bus.lkp_valid_i = 1'b0;
        check("cr_valid", bus.cr_valid_o, 1);
        check("cr_resp", 64'(bus.cr_resp_o), 64'(e_resp));
        stall = (cr_stall >= 0) ? cr_stall : int'($urandom_range(0, max_dly));
        repeat (stall) begin
            bus.lkp_valid_i = 1'($urandom_range(0, 1));
            {bus.lkp_hit_i, bus.lkp_dirty_i, bus.lkp_shared_i} = ~{hit, dirty, shared};
            step();
            bus.lkp_valid_i = 1'b0;
            check("cr_valid_stall", bus.cr_valid_o, 1);
            check("cr_resp_stall", 64'(bus.cr_resp_o), 64'(e_resp));
        end
        bus.cr_ready_i = 1'b1;
        step();
        bus.cr_ready_i = 1'b0;
        check("cr_drop", bus.cr_valid_o, 0);
        if (e_dt) begin
            for (int b = 0; b < BEATS; b++) begin
                check("rd_req", bus.rd_req_o, 1);
                check("rd_beat", 64'(bus.rd_beat_o), 64'(b));
                check("cd_before_rd", bus.cd_valid_o, 0);
                repeat ($urandom_range(0, max_dly)) step();
                bus.rd_gnt_i = 1'b1;
                step();
                bus.rd_gnt_i = 1'b0;
                repeat ($urandom_range(0, max_dly)) begin
                    check("cd_early", bus.cd_valid_o, 0);
                    step();
                end
                exp_q.push_back(line_word(line, b));
                bus.rd_valid_i = 1'b1;
                bus.rd_data_i  = line_word(line, b);
                step();
                bus.rd_valid_i = 1'b0;
                check("cd_valid", bus.cd_valid_o, 1);
                check("cd_last", bus.cd_last_o, (b == BEATS - 1));
                if (b == rst_beat) begin
                    rst = 1'b1;
                    step();
                    check_quiet("rst_mid");
                    rst = 1'b0;
                    exp_q.delete();
                    repeat (8) begin
                        step();
                        check("post_rst_quiet", {bus.cr_valid_o, bus.cd_valid_o, bus.upd_valid_o,
                                                 bus.rd_req_o, bus.lkp_req_o}, 0);
                    end
                    return;
                end
                repeat ($urandom_range(0, max_dly)) begin
                    bus.rd_valid_i = 1'($urandom_range(0, 1));
                    bus.rd_data_i  = {$urandom, $urandom};
                    step();
                    bus.rd_valid_i = 1'b0;
                    check("cd_valid_stall", bus.cd_valid_o, 1);
                    check("cd_last_stall", bus.cd_last_o, (b == BEATS - 1));
                end
                w = exp_q.pop_front();
                check("cd_data", bus.cd_data_o, w);
                bus.cd_ready_i = 1'b1;
                step();
                bus.cd_ready_i = 1'b0;
            end
        end
        check("cd_after", bus.cd_valid_o, 0);
        if (e_upd != 3'b0) begin
            check("upd_valid", bus.upd_valid_o, 1);
            check("upd_bits", 64'({bus.upd_inval_o, bus.upd_clean_o, bus.upd_share_o}), 64'(e_upd));
            step();
        end
        check("upd_none", bus.upd_valid_o, 0);
        check("ac_ready_back", bus.ac_ready_o, 1);
    endtask

    initial begin
        bus.ac_valid_i = 1'b0; bus.ac_addr_i = '0; bus.ac_snoop_i = '0; bus.ac_prot_i = '0;
        bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0; bus.lkp_gnt_i = 1'b0; bus.lkp_valid_i = 1'b0;
        bus.lkp_hit_i = 1'b0; bus.lkp_dirty_i = 1'b0; bus.lkp_shared_i = 1'b0;
        bus.rd_gnt_i = 1'b0; bus.rd_valid_i = 1'b0; bus.rd_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        step();
        check("state_after_rst", 64'(dbg_state), 64'(ST_IDLE));

        run_snoop(SNP_READ_SHARED, 64'h1040, 1, 1, 0, 0, 0, -1);
        run_snoop(SNP_READ_UNIQUE, 64'h2000, 1, 0, 1, 0, 0, -1);
        run_snoop(SNP_MAKE_INVALID, 64'h3080, 1, 1, 0, 0, 0, -1);
        run_snoop(SNP_READ_SHARED, 64'h4000, 0, 1, 0, 0, 0, -1);
        run_snoop(SNP_CLEAN_INVALID, 64'h40C0, 0, 0, 1, 0, 0, -1);
        run_snoop(SNP_CLEAN_SHARED, 64'h5000, 1, 0, 0, 0, 0, -1);
        run_snoop(SNP_READ_NSD, 64'h107F, 1, 1, 1, 3, 5, -1);
        run_snoop(SNP_READ_UNIQUE, 64'h6040, 1, 1, 0, 2, -1, 3);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] ops[11];
            ops = '{SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD, SNP_READ_UNIQUE,
                    SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID, 4'b0100, 4'b1011, 4'b1111};
            run_snoop(ops[$urandom_range(0, 10)], {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
